imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time loader that receives a byte stream and writes it word-by-word into the CPU's instruction memory, holding the CPU in reset until the image is complete. It sits between an external byte source (UART receiver or testbench) and the instruction-memory write port; the CPU fetch path is the reader of the same memory. A `reload` input re-arms the block so that a new program can be loaded without a global reset.

## Interface
- `ADDRESS_WIDTH`, 5, instruction-memory word-address width; legal range 1..8.
- `DATA_WIDTH`, 32, instruction word width; fixed at 32.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: byte available on `in_data`.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader can accept a byte; a byte transfers on a rising edge where `in_valid && in_ready`.
- `reload` input 1: single-cycle pulse; honoured only in DONE or ERROR.
- `we` output 1: instruction-memory write enable, one-cycle pulse per word.
- `waddr` output ADDRESS_WIDTH: word address of the write.
- `wdata` output DATA_WIDTH: word to write.
- `cpu_rst` output 1: high while the CPU must be held in reset.
- `done` output 1: image loaded successfully.
- `error` output 1: load rejected.

## Operation
- Stream format: a length byte N (number of words), then 4·N payload bytes, little-endian within each word (the first byte received is `wdata[7:0]`).
- States: IDLE (await length byte), LOAD (collect payload), DONE, ERROR; plus CHECK when the checksum feature is compiled in.
- IDLE: on a length-byte handshake:
  - N = 0 → DONE (or CHECK).
  - N > 2^ADDRESS_WIDTH → ERROR.
  - Otherwise → LOAD, with the word counter at 0.
- LOAD: a 2-bit byte index selects the lane. On the 4th byte:
  - Register `we=1`, `waddr` = word counter, `wdata` = assembled word.
  - Increment the word counter.
  - After word N−1 → DONE (or CHECK).
- `in_ready` = 1 in IDLE, LOAD and CHECK; 0 in DONE and ERROR. `in_ready` is a combinational decode of state.
- `cpu_rst` = 1 in every state except DONE. `done` = (state==DONE). `error` = (state==ERROR).
- `reload` in DONE or ERROR → IDLE; this clears the counters and the partial word and reasserts `cpu_rst`. `reload` is ignored in other states.
- Reset values: state IDLE, `we` 0, `waddr` 0, `wdata` 0, `cpu_rst` 1, `done` 0, `error` 0. `in_ready` is 1, by decode of IDLE.
- A reset mid-load discards the partial word. Words already written remain in memory; the loader does not clear them.
- Gaps in `in_valid` are legal anywhere; the byte index and counters hold while no handshake occurs.

## Timing
- A 4th-byte handshake at edge k gives `we`/`waddr`/`wdata` valid for exactly one cycle after edge k, then `we` returns to 0.
- Last-word handshake at edge k:
  - State becomes DONE at edge k.
  - `done`=1 and `cpu_rst`=0 from edge k onward.
  - The final `we` pulse is coincident with that cycle. The memory write completes at edge k+1, before the CPU's first fetch edge.
- Throughput: one byte per cycle; there is no internal backpressure in LOAD.
- A length-byte handshake to ERROR gives `error`=1 the next cycle, with `in_ready`=0.
- `reload` at edge k gives IDLE, `cpu_rst`=1 and `done`=0 after edge k.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last word (or immediately for N=0), enter CHECK and accept one checksum byte.
  - The checksum must equal the XOR of the length byte and all payload bytes.
  - Match → DONE. Mismatch → ERROR, with `cpu_rst` held at 1.
  - The running XOR is cleared on `rst` and on `reload`.
- Undefined: no CHECK state and no XOR register. The stream ends at the last payload byte.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum `loader_state_t` (IDLE, LOAD, CHECK, DONE, ERROR);
  - the constant `STREAM_BYTES_PER_WORD = 4`.
- Sub-module `word_assembler` contains the byte-lane shift register, the 2-bit index, and a `word_valid` strobe. The top level owns the FSM, the word counter and the output registers.

## Test plan
- N=2, bytes 13 00 50 00 / 93 00 10 00 → two `we` pulses: addr 0 data 0x00500013, then addr 1 data 0x00100093. After the last byte, `cpu_rst`=0 and `done`=1.
- N=0 → no `we` pulse; DONE after one cycle, with `cpu_rst`=0.
- N=33 with ADDRESS_WIDTH=5 → `error`=1, `in_ready`=0, `cpu_rst`=1, and no `we` pulse.
- N=1 with `in_valid` deasserted for 3 cycles between each byte → a single write of the correct word; `we` is never asserted early.
- `rst` pulse after 6 of 8 payload bytes → outputs return to reset values; a full new image then loads correctly from address 0.
- With `IMEM_LOADER_CHECKSUM_EN`: N=1, word 0x00000013, checksum 0x12 → DONE. Checksum 0x00 → ERROR. `reload` from ERROR → IDLE with `cpu_rst`=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the boot-time instruction-memory loader.
//   Contents:
//     loader_state_t        : loader FSM states (IDLE, LOAD, CHECK, DONE, ERROR)
//     STREAM_BYTES_PER_WORD : payload bytes per instruction word (4)
//     length_too_big()      : true when a length byte exceeds memory depth
// ----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    localparam int STREAM_BYTES_PER_WORD = 4;

    // A length of exactly 2^aw words fills the memory and is still legal,
    // so the comparison is strictly greater-than on a 9-bit value.
    function automatic logic length_too_big(input logic [7:0] n, input int aw);
        logic [8:0] depth;
        depth = 9'd1 << aw;
        return ({1'b0, n} > depth);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// ----------------------------------------------------------------------------
// word_assembler
//   Collects little-endian stream bytes into 32-bit instruction words.
//   Ports:
//     clk, rst    : clock and asynchronous active-high reset
//     clear       : synchronous clear of the partial word and byte index
//     byte_valid  : a payload byte is transferring this cycle
//     byte_data   : the payload byte
//     word_valid  : combinational strobe, high with the 4th byte of a word
//     word_data   : assembled word, meaningful while word_valid is high
// ----------------------------------------------------------------------------
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam logic [1:0] LAST_LANE = 2'(STREAM_BYTES_PER_WORD - 1);

    // Only the first three bytes of a word need storage; the fourth byte is
    // combined directly with them when the word is presented.
    logic [23:0] shift_reg;
    logic [1:0]  byte_index;

    // Shift new bytes in at the top so the first byte received ends up in
    // the lowest lane once three bytes have arrived. The index wraps
    // naturally after the fourth byte, starting the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            byte_index <= '0;
        end else if (clear) begin
            shift_reg  <= '0;
            byte_index <= '0;
        end else if (byte_valid) begin
            shift_reg  <= {byte_data, shift_reg[23:8]};
            byte_index <= byte_index + 2'd1;
        end
    end

    assign word_valid = byte_valid && (byte_index == LAST_LANE);
    assign word_data  = {byte_data, shift_reg};

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Boot-time loader: receives a length byte N followed by 4*N little-endian
//   payload bytes and writes them as words into instruction memory, holding
//   the CPU in reset until the image is complete. 'reload' re-arms the loader
//   from DONE or ERROR without a global reset.
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum
//   byte (XOR of length and payload) verified in a CHECK state.
//   Ports:
//     clk, rst           : clock and asynchronous active-high reset
//     in_valid, in_data  : incoming byte stream
//     in_ready           : loader can accept a byte (decode of state)
//     reload             : single-cycle re-arm pulse (DONE/ERROR only)
//     we, waddr, wdata   : registered instruction-memory write port
//     cpu_rst            : holds the CPU in reset (low only in DONE)
//     done, error        : load finished / load rejected
// ----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     reload,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic                     cpu_rst,
    output logic                     done,
    output logic                     error
);

    loader_state_t state;
    loader_state_t next_state;

    logic        handshake;
    logic        reload_take;
    logic [7:0]  length;
    logic [8:0]  word_cnt;
    logic        last_word;
    logic        word_valid;
    logic [31:0] word_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    assign in_ready    = (state == IDLE) || (state == LOAD) || (state == CHECK);
    assign handshake   = in_valid && in_ready;
    assign reload_take = reload && ((state == DONE) || (state == ERROR));
    assign last_word   = (word_cnt == ({1'b0, length} - 9'd1));

    assign cpu_rst = (state != DONE);
    assign done    = (state == DONE);
    assign error   = (state == ERROR);

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload_take),
        .byte_valid (handshake && (state == LOAD)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. The image ends either at the last payload byte or,
    // with the checksum feature, at the checksum byte that follows it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    if (in_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        next_state = CHECK;
`else
                        next_state = DONE;
`endif
                    end else if (length_too_big(in_data, ADDRESS_WIDTH)) begin
                        next_state = ERROR;
                    end else begin
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = CHECK;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (handshake) begin
                    next_state = (in_data == checksum) ? DONE : ERROR;
                end
            end
`endif
            DONE, ERROR: begin
                if (reload) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Length capture and word counter. The counter restarts with every
    // length byte so a reloaded image always begins at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length   <= '0;
            word_cnt <= '0;
        end else if (reload_take) begin
            length   <= '0;
            word_cnt <= '0;
        end else if (handshake && (state == IDLE)) begin
            length   <= in_data;
            word_cnt <= '0;
        end else if (word_valid) begin
            word_cnt <= word_cnt + 9'd1;
        end
    end

    // Registered write port: one-cycle 'we' pulse per completed word, with
    // address and data held until the next word or a reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= 1'b0;
            if (reload_take) begin
                waddr <= '0;
                wdata <= '0;
            end else if (word_valid) begin
                we    <= 1'b1;
                waddr <= word_cnt[ADDRESS_WIDTH-1:0];
                wdata <= word_data;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over the length byte and every payload byte; the length
    // byte seeds it so a fresh image never sees a stale value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (reload_take) begin
            checksum <= '0;
        end else if (handshake && (state == IDLE)) begin
            checksum <= in_data;
        end else if (handshake && (state == LOAD)) begin
            checksum <= checksum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Stimulus pushes expected memory
//   writes into a scoreboard; a monitor pops and compares on every 'we'.
//   Status outputs are compared directly after each scenario.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          reload;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          cpu_rst;
    logic          done;
    logic          error;

    int total;
    int bad;

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    logic [31:0]   img_words[$];

    imem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reload   (reload),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .error    (error)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && we) begin
            if (exp_addr_q.size() == 0) begin
                check_output("unexpected_we", {27'd0, waddr}, 32'hFFFF_FFFF);
            end else begin
                check_output("waddr", {27'd0, waddr}, {27'd0, exp_addr_q.pop_front()});
                check_output("wdata", wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    // Send length byte plus 'sent' payload bytes taken from img_words. The
    // expected write is queued just before the byte that completes a word.
    task automatic apply_stimulus(input logic [7:0] len, input int gap, input int sent);
        logic [7:0]  csum;
        logic [7:0]  b;
        logic [31:0] w;
        csum = len;
        send_byte(len, gap);
        for (int i = 0; i < sent; i++) begin
            w = img_words[i / 4];
            b = w[8 * (i % 4) +: 8];
            csum = csum ^ b;
            if ((i % 4) == 3) begin
                exp_addr_q.push_back(AW'(i / 4));
                exp_data_q.push_back(w);
            end
            send_byte(b, gap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (sent == 4 * int'(len)) begin
            send_byte(csum, gap);
        end
`endif
    endtask

    task automatic check_status(input string tag, input logic e_done,
                                input logic e_error, input logic e_cpu_rst,
                                input logic e_ready);
        check_output({tag, "_done"},     {31'd0, done},     {31'd0, e_done});
        check_output({tag, "_error"},    {31'd0, error},    {31'd0, e_error});
        check_output({tag, "_cpu_rst"},  {31'd0, cpu_rst},  {31'd0, e_cpu_rst});
        check_output({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, e_ready});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) tick();

        // Reset values.
        check_output("rst_we",    {31'd0, we},    32'd0);
        check_output("rst_waddr", {27'd0, waddr}, 32'd0);
        check_output("rst_wdata", wdata,          32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        tick();

        // Two-word image.
        img_words = {32'h0050_0013, 32'h0010_0093};
        apply_stimulus(8'd2, 0, 8);
        check_status("n2", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        check_output("n2_we_drop", {31'd0, we}, 32'd0);

        // Reload from DONE.
        pulse_reload();
        check_status("reload_done", 1'b0, 1'b0, 1'b1, 1'b1);

        // Empty image.
        img_words = {};
        apply_stimulus(8'd0, 0, 0);
        check_status("n0", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_reload();

        // Oversized image: 33 words into a 32-word memory.
        apply_stimulus(8'd33, 0, 0);
        check_status("n33", 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        check_status("n33_hold", 1'b0, 1'b1, 1'b1, 1'b0);
        pulse_reload();
        check_status("reload_err", 1'b0, 1'b0, 1'b1, 1'b1);

        // One word with three idle cycles between bytes.
        img_words = {32'h0000_1237};
        apply_stimulus(8'd1, 3, 4);
        check_status("gap", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_reload();

        // Reset after 6 of 8 payload bytes, then a fresh image from address 0.
        img_words = {32'h1111_2222, 32'h3333_4444};
        apply_stimulus(8'd2, 0, 6);
        check_status("partial", 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        #2;
        check_output("mid_rst_we",    {31'd0, we},    32'd0);
        check_output("mid_rst_waddr", {27'd0, waddr}, 32'd0);
        check_output("mid_rst_wdata", wdata,          32'd0);
        check_status("mid_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        img_words = {32'hDEAD_BEEF, 32'h0123_4567};
        apply_stimulus(8'd2, 0, 8);
        check_status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_reload();

        // Full-depth image: 32 words, last address 31.
        img_words = {};
        for (int i = 0; i < 32; i++) begin
            img_words.push_back({8'(i + 1), ~8'(i), 8'hA5, 8'(i)});
        end
        apply_stimulus(8'd32, 0, 128);
        check_status("n32", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_reload();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum 0x01 ^ 0x13 = 0x12 accepts the image.
        exp_addr_q.push_back('0);
        exp_data_q.push_back(32'h0000_0013);
        send_byte(8'h01, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_status("cs_wait", 1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h12, 0);
        check_status("cs_good", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_reload();

        // Wrong checksum rejects it and keeps the CPU in reset.
        exp_addr_q.push_back('0);
        exp_data_q.push_back(32'h0000_0013);
        send_byte(8'h01, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_status("cs_bad", 1'b0, 1'b1, 1'b1, 1'b0);
        pulse_reload();
        check_status("cs_reload", 1'b0, 1'b0, 1'b1, 1'b1);
`endif

        repeat (3) tick();
        check_output("sb_empty", exp_addr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
